// File: rtl/eq_word_seq_ctrl.sv
// eq_word_seq_ctrl: compares two multi-nibble words one nibble per cycle
// through an external shared 4-bit equality comparator, LSB nibble first.
// Reports word equality, the first mismatching nibble index and the count
// of mismatching nibbles seen.
module eq_word_seq_ctrl #(
  parameter int NIBBLES    = 4,
  parameter int EARLY_EXIT = 1,
  localparam int W  = 4 * NIBBLES,
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1,
  localparam int CW = $clog2(NIBBLES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  B,
  output logic [3:0]    cmp_a,
  output logic [3:0]    cmp_b,
  input  logic          cmp_c,
  output logic          busy,
  output logic          done,
  output logic          C,
  output logic [IW-1:0] mism_idx,
  output logic [CW-1:0] mism_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          eq_acc_q, eq_acc_d;
  logic          first_found_q, first_found_d;
  logic [IW-1:0] first_idx_q, first_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          c_q, c_d;
  logic [IW-1:0] mism_idx_q, mism_idx_d;
  logic [CW-1:0] mism_cnt_q, mism_cnt_d;

  logic          last_nibble;
  logic          finish_now;

  // Next-state, accumulator and comparator-drive logic for the sequencer.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    idx_d         = idx_q;
    eq_acc_d      = eq_acc_q;
    first_found_d = first_found_q;
    first_idx_d   = first_idx_q;
    cnt_d         = cnt_q;
    c_d           = c_q;
    mism_idx_d    = mism_idx_q;
    mism_cnt_d    = mism_cnt_q;
    cmp_a         = 4'd0;
    cmp_b         = 4'd0;
    last_nibble   = (idx_q == IW'(NIBBLES - 1));
    finish_now    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d           = A;
          b_d           = B;
          idx_d         = '0;
          eq_acc_d      = 1'b1;
          first_found_d = 1'b0;
          first_idx_d   = '0;
          cnt_d         = '0;
          state_d       = ST_CMP;
        end
      end

      ST_CMP: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IW'(i)) begin
            cmp_a = a_q[4*i +: 4];
            cmp_b = b_q[4*i +: 4];
          end
        end

        if (!cmp_c) begin
          cnt_d    = cnt_q + CW'(1);
          eq_acc_d = 1'b0;
          if (!first_found_q) begin
            first_found_d = 1'b1;
            first_idx_d   = idx_q;
          end
        end

        finish_now = last_nibble || ((EARLY_EXIT != 0) && !cmp_c);

        if (finish_now) begin
          state_d    = ST_DONE;
          c_d        = eq_acc_d;
          mism_idx_d = first_idx_d;
          mism_cnt_d = cnt_d;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, operand, accumulator and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      a_q           <= '0;
      b_q           <= '0;
      idx_q         <= '0;
      eq_acc_q      <= 1'b1;
      first_found_q <= 1'b0;
      first_idx_q   <= '0;
      cnt_q         <= '0;
      c_q           <= 1'b0;
      mism_idx_q    <= '0;
      mism_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      idx_q         <= idx_d;
      eq_acc_q      <= eq_acc_d;
      first_found_q <= first_found_d;
      first_idx_q   <= first_idx_d;
      cnt_q         <= cnt_d;
      c_q           <= c_d;
      mism_idx_q    <= mism_idx_d;
      mism_cnt_q    <= mism_cnt_d;
    end
  end

  // Status flags decode straight from the state register; results are registered.
  always_comb begin
    busy     = (state_q == ST_CMP) || (state_q == ST_DONE);
    done     = (state_q == ST_DONE);
    C        = c_q;
    mism_idx = mism_idx_q;
    mism_cnt = mism_cnt_q;
  end

endmodule

// File: tb/tb_eq_word_seq_ctrl.sv
// tb_eq_word_seq_ctrl: directed bench for eq_word_seq_ctrl. One instance
// runs with early exit, one compares all nibbles; each has its own 4-bit
// equality comparator on cmp_a/cmp_b/cmp_c.
module tb_eq_word_seq_ctrl;

  logic        clk;
  logic        rst;

  logic        start_e, start_f;
  logic [15:0] a_e, b_e, a_f, b_f;
  logic [3:0]  cmp_a_e, cmp_b_e, cmp_a_f, cmp_b_f;
  logic        cmp_c_e, cmp_c_f;
  logic        busy_e, busy_f, done_e, done_f, c_e, c_f;
  logic [1:0]  idx_e, idx_f;
  logic [2:0]  cnt_e, cnt_f;

  int tests_run;
  int failures;

  logic       held_c   [2];
  logic [1:0] held_idx [2];
  logic [2:0] held_cnt [2];

  eq_word_seq_ctrl #(.NIBBLES(4), .EARLY_EXIT(1)) dut_e (
    .clk(clk), .rst(rst), .start(start_e), .A(a_e), .B(b_e),
    .cmp_a(cmp_a_e), .cmp_b(cmp_b_e), .cmp_c(cmp_c_e),
    .busy(busy_e), .done(done_e), .C(c_e), .mism_idx(idx_e), .mism_cnt(cnt_e)
  );

  eq_word_seq_ctrl #(.NIBBLES(4), .EARLY_EXIT(0)) dut_f (
    .clk(clk), .rst(rst), .start(start_f), .A(a_f), .B(b_f),
    .cmp_a(cmp_a_f), .cmp_b(cmp_b_f), .cmp_c(cmp_c_f),
    .busy(busy_f), .done(done_f), .C(c_f), .mism_idx(idx_f), .mism_cnt(cnt_f)
  );

  // Shared nibble comparators seen by each controller.
  assign cmp_c_e = (cmp_a_e == cmp_b_e);
  assign cmp_c_f = (cmp_a_f == cmp_b_f);

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time bound so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // which: 0 busy, 1 done, 2 C, 3 mism_idx, 4 mism_cnt, 5 cmp_a, 6 cmp_b
  function automatic logic [31:0] getObs(input bit full, input int which);
    logic [31:0] v;
    v = '0;
    case (which)
      0: v = full ? 32'(busy_f)  : 32'(busy_e);
      1: v = full ? 32'(done_f)  : 32'(done_e);
      2: v = full ? 32'(c_f)     : 32'(c_e);
      3: v = full ? 32'(idx_f)   : 32'(idx_e);
      4: v = full ? 32'(cnt_f)   : 32'(cnt_e);
      5: v = full ? 32'(cmp_a_f) : 32'(cmp_a_e);
      6: v = full ? 32'(cmp_b_f) : 32'(cmp_b_e);
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic applyStimulus(input bit full, input logic st, input logic [15:0] a, input logic [15:0] b);
    if (full) begin
      start_f = st;
      a_f     = a;
      b_f     = b;
    end else begin
      start_e = st;
      a_e     = a;
      b_e     = b;
    end
  endtask

  task automatic checkResults(input string tag, input bit full, input logic c, input logic [1:0] idx, input logic [2:0] cnt);
    checkOutput({tag, " C"},        getObs(full, 2), 32'(c));
    checkOutput({tag, " mism_idx"}, getObs(full, 3), 32'(idx));
    checkOutput({tag, " mism_cnt"}, getObs(full, 4), 32'(cnt));
  endtask

  // One start pulse, then cycle-by-cycle checks through done and some idle cycles.
  task automatic runOp(input string name, input bit full, input logic [15:0] a, input logic [15:0] b,
                       input int done_cyc, input logic exp_c, input logic [1:0] exp_idx,
                       input logic [2:0] exp_cnt, input int idle_after);
    logic [3:0] ea, eb;
    applyStimulus(full, 1'b1, a, b);
    @(posedge clk); #1;
    applyStimulus(full, 1'b0, ~a, ~b);
    for (int k = 1; k <= done_cyc + idle_after; k++) begin
      @(negedge clk);
      checkOutput($sformatf("%s busy c%0d", name, k), getObs(full, 0), 32'(k <= done_cyc));
      checkOutput($sformatf("%s done c%0d", name, k), getObs(full, 1), 32'(k == done_cyc));
      if (k < done_cyc) begin
        ea = a[4*(k-1) +: 4];
        eb = b[4*(k-1) +: 4];
        checkResults($sformatf("%s held c%0d", name, k), full, held_c[full], held_idx[full], held_cnt[full]);
      end else begin
        ea = 4'd0;
        eb = 4'd0;
        checkResults($sformatf("%s result c%0d", name, k), full, exp_c, exp_idx, exp_cnt);
      end
      checkOutput($sformatf("%s cmp_a c%0d", name, k), getObs(full, 5), 32'(ea));
      checkOutput($sformatf("%s cmp_b c%0d", name, k), getObs(full, 6), 32'(eb));
      @(posedge clk); #1;
    end
    held_c[full]   = exp_c;
    held_idx[full] = exp_idx;
    held_cnt[full] = exp_cnt;
  endtask

  function automatic logic [15:0] b2bA(input int k);
    logic [3:0] n;
    n = 4'(k);
    case (k)
      0:       return 16'h1234;
      6:       return 16'hABCD;
      12:      return 16'h5555;
      default: return {n, n, n, n};
    endcase
  endfunction

  function automatic logic [15:0] b2bB(input int k);
    logic [3:0] n;
    n = 4'(k);
    case (k)
      0:       return 16'h1234;
      6:       return 16'h0BCD;
      12:      return 16'h5AA5;
      default: return ~{n, n, n, n};
    endcase
  endfunction

  // Directed test sequence.
  initial begin
    logic       exp_c_b2b   [3];
    logic [1:0] exp_idx_b2b [3];
    logic [2:0] exp_cnt_b2b [3];
    logic [15:0] op_a, op_b;
    int phase, op;

    tests_run = 0;
    failures  = 0;
    for (int d = 0; d < 2; d++) begin
      held_c[d]   = 1'b0;
      held_idx[d] = 2'd0;
      held_cnt[d] = 3'd0;
    end

    // Reset held two cycles with start high on both instances.
    rst = 1'b1;
    start_e = 1'b1; a_e = 16'h1111; b_e = 16'h2222;
    start_f = 1'b1; a_f = 16'h3333; b_f = 16'h3333;
    for (int e = 1; e <= 2; e++) begin
      @(posedge clk); #1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checkOutput($sformatf("reset busy d%0d e%0d", d, e), getObs(d[0], 0), 32'd0);
        checkOutput($sformatf("reset done d%0d e%0d", d, e), getObs(d[0], 1), 32'd0);
        checkResults($sformatf("reset d%0d e%0d", d, e), d[0], 1'b0, 2'd0, 3'd0);
        checkOutput($sformatf("reset cmp_a d%0d e%0d", d, e), getObs(d[0], 5), 32'd0);
        checkOutput($sformatf("reset cmp_b d%0d e%0d", d, e), getObs(d[0], 6), 32'd0);
      end
    end
    rst = 1'b0;
    start_e = 1'b0;
    start_f = 1'b0;
    @(posedge clk); #1;

    // Equal words with early exit: all four nibbles, done in cycle 5.
    runOp("eq", 1'b0, 16'hA5A5, 16'hA5A5, 5, 1'b1, 2'd0, 3'd0, 2);

    // Mismatch at nibble 1 with early exit: done in cycle 3, results hold.
    runOp("early", 1'b0, 16'h1234, 16'h1294, 3, 1'b0, 2'd1, 3'd1, 3);

    // Full compare: mismatches at nibbles 1 and 3.
    runOp("full", 1'b1, 16'hFFFF, 16'h0F0F, 5, 1'b0, 2'd1, 3'd2, 2);

    // Back-to-back with start held and operands changing every cycle.
    exp_c_b2b[0] = 1'b1; exp_idx_b2b[0] = 2'd0; exp_cnt_b2b[0] = 3'd0;
    exp_c_b2b[1] = 1'b0; exp_idx_b2b[1] = 2'd3; exp_cnt_b2b[1] = 3'd1;
    exp_c_b2b[2] = 1'b0; exp_idx_b2b[2] = 2'd1; exp_cnt_b2b[2] = 3'd2;
    applyStimulus(1'b1, 1'b1, b2bA(0), b2bB(0));
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      applyStimulus(1'b1, (k < 18), b2bA(k), b2bB(k));
      @(negedge clk);
      phase = ((k - 1) % 6) + 1;
      op    = (k - 1) / 6;
      op_a  = b2bA(op * 6);
      op_b  = b2bB(op * 6);
      checkOutput($sformatf("b2b busy c%0d", k), getObs(1'b1, 0), 32'(phase <= 5));
      checkOutput($sformatf("b2b done c%0d", k), getObs(1'b1, 1), 32'(phase == 5));
      if (phase <= 4) begin
        checkOutput($sformatf("b2b cmp_a c%0d", k), getObs(1'b1, 5), 32'(op_a[4*(phase-1) +: 4]));
        checkOutput($sformatf("b2b cmp_b c%0d", k), getObs(1'b1, 6), 32'(op_b[4*(phase-1) +: 4]));
      end else begin
        checkOutput($sformatf("b2b cmp_a c%0d", k), getObs(1'b1, 5), 32'd0);
      end
      if (phase == 5) begin
        held_c[1]   = exp_c_b2b[op];
        held_idx[1] = exp_idx_b2b[op];
        held_cnt[1] = exp_cnt_b2b[op];
      end
      checkResults($sformatf("b2b c%0d", k), 1'b1, held_c[1], held_idx[1], held_cnt[1]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("b2b idle after release", getObs(1'b1, 0), 32'd0);
    @(posedge clk); #1;

    // Reset mid-compare, with start raised on the same edge.
    applyStimulus(1'b1, 1'b1, 16'h0000, 16'h0001);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0001);
    @(negedge clk);
    checkOutput("abort busy c1", getObs(1'b1, 0), 32'd1);
    checkOutput("abort cmp_b c1", getObs(1'b1, 6), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 16'h0000, 16'h0001);
    @(negedge clk);
    checkOutput("abort busy c2", getObs(1'b1, 0), 32'd1);
    checkOutput("abort done c2", getObs(1'b1, 1), 32'd0);
    checkResults("abort held c2", 1'b1, held_c[1], held_idx[1], held_cnt[1]);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0001);
    for (int d = 0; d < 2; d++) begin
      held_c[d]   = 1'b0;
      held_idx[d] = 2'd0;
      held_cnt[d] = 3'd0;
    end
    for (int k = 3; k <= 6; k++) begin
      @(negedge clk);
      checkOutput($sformatf("abort busy c%0d", k), getObs(1'b1, 0), 32'd0);
      checkOutput($sformatf("abort done c%0d", k), getObs(1'b1, 1), 32'd0);
      checkOutput($sformatf("abort cmp_a c%0d", k), getObs(1'b1, 5), 32'd0);
      checkResults($sformatf("abort c%0d", k), 1'b1, 1'b0, 2'd0, 3'd0);
      @(posedge clk); #1;
    end

    // Fresh operation after the abort completes normally.
    runOp("fresh", 1'b1, 16'h0000, 16'h0001, 5, 1'b0, 2'd0, 3'd1, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
